// File: rtl/Utilities.sv
// Shared ALU definitions: uop encoding, NZCV flags, scheduler state and the flag-update predicate.
package Utilities;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned UOP_W  = 5;

    localparam logic [UOP_W-1:0] UOP_NOP = 5'd0;
    localparam logic [UOP_W-1:0] UOP_ADD = 5'd1;
    localparam logic [UOP_W-1:0] UOP_SUB = 5'd2;
    localparam logic [UOP_W-1:0] UOP_AND = 5'd3;
    localparam logic [UOP_W-1:0] UOP_EOR = 5'd4;
    localparam logic [UOP_W-1:0] UOP_CMP = 5'd5;
    localparam logic [UOP_W-1:0] UOP_LSL = 5'd6;
    localparam logic [UOP_W-1:0] UOP_LSR = 5'd7;
    localparam logic [UOP_W-1:0] UOP_MOV = 5'd8;
    localparam logic [UOP_W-1:0] UOP_STR = 5'd9;
    localparam logic [UOP_W-1:0] UOP_LDR = 5'd10;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } Flags;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } sched_state_t;

    function automatic logic uop_sets_flags(input logic [UOP_W-1:0] uop);
        case (uop)
            UOP_ADD, UOP_SUB, UOP_AND, UOP_EOR,
            UOP_CMP, UOP_LSL, UOP_LSR, UOP_MOV: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit ALU; C is bit 32 of the 33-bit result, V signed overflow for add/sub.
module ALU
    import Utilities::*;
(
    input  logic [DATA_W-1:0] lhs,
    input  logic [DATA_W-1:0] rhs,
    input  logic [UOP_W-1:0]  uop,
    output logic [DATA_W-1:0] result,
    output Flags              flags
);

    logic [DATA_W:0] wide;
    logic            ovf;

    always_comb begin
        wide = '0;
        ovf  = 1'b0;
        case (uop)
            UOP_ADD, UOP_LDR, UOP_STR: begin
                wide = {1'b0, lhs} + {1'b0, rhs};
                ovf  = (lhs[31] == rhs[31]) && (wide[31] != lhs[31]);
            end
            UOP_SUB, UOP_CMP: begin
                wide = {1'b0, lhs} - {1'b0, rhs};
                ovf  = (lhs[31] != rhs[31]) && (wide[31] != lhs[31]);
            end
            UOP_AND: wide = {1'b0, lhs & rhs};
            UOP_EOR: wide = {1'b0, lhs ^ rhs};
            UOP_LSL: wide = {1'b0, lhs} << rhs[4:0];
            UOP_LSR: wide = {1'b0, lhs >> rhs[4:0]};
            UOP_MOV: wide = {1'b0, rhs};
            default: wide = '0;
        endcase
        result  = wide[DATA_W-1:0];
        flags.n = wide[31];
        flags.z = (wide[DATA_W-1:0] == '0);
        flags.c = wide[DATA_W];
        flags.v = ovf;
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-port scheduler for the shared ALU with per-port response slots and the NZCV register.
// ALU_SCHED_RR_EN selects round-robin contention; otherwise port A has fixed priority.
module alu_scheduler
    import Utilities::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_lhs,
    input  logic [DATA_W-1:0] a_rhs,
    input  logic [UOP_W-1:0]  a_uop,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_lhs,
    input  logic [DATA_W-1:0] b_rhs,
    input  logic [UOP_W-1:0]  b_uop,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_data,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_data,
    output Flags              flags_out
);

    logic              elig_a, elig_b;
    logic              grant_a, grant_b;
    logic [DATA_W-1:0] alu_lhs, alu_rhs, alu_result;
    logic [UOP_W-1:0]  alu_uop;
    Flags              alu_flags;

    // A port may issue when its slot is empty or is being drained this cycle.
    assign elig_a = a_valid && (!a_rsp_valid || a_rsp_ready);
    assign elig_b = b_valid && (!b_rsp_valid || b_rsp_ready);

`ifdef ALU_SCHED_RR_EN
    sched_state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= PRIO_A;
        else          state <= state_nxt;
    end

    // Contention hands priority to the loser; uncontested grants keep it.
    always_comb begin
        state_nxt = state;
        if (elig_a && elig_b) state_nxt = (state == PRIO_A) ? PRIO_B : PRIO_A;
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset_n) begin
            if (elig_a && elig_b) begin
                grant_a = (state == PRIO_A);
                grant_b = (state == PRIO_B);
            end else begin
                grant_a = elig_a;
                grant_b = elig_b;
            end
        end
    end
`else
    always_comb begin
        grant_a = reset_n && elig_a;
        grant_b = reset_n && elig_b && !elig_a;
    end
`endif

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Idle cycles present NOP with zero operands to the ALU.
    always_comb begin
        alu_lhs = '0;
        alu_rhs = '0;
        alu_uop = UOP_NOP;
        if (grant_a) begin
            alu_lhs = a_lhs;
            alu_rhs = a_rhs;
            alu_uop = a_uop;
        end else if (grant_b) begin
            alu_lhs = b_lhs;
            alu_rhs = b_rhs;
            alu_uop = b_uop;
        end
    end

    ALU u_alu (
        .lhs    (alu_lhs),
        .rhs    (alu_rhs),
        .uop    (alu_uop),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // A grant reloads its slot even while the old result is being consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rsp_valid <= 1'b0;
            a_rsp_data  <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_data  <= '0;
            flags_out   <= '0;
        end else begin
            if (grant_a) begin
                a_rsp_valid <= 1'b1;
                a_rsp_data  <= alu_result;
            end else if (a_rsp_ready) begin
                a_rsp_valid <= 1'b0;
            end
            if (grant_b) begin
                b_rsp_valid <= 1'b1;
                b_rsp_data  <= alu_result;
            end else if (b_rsp_ready) begin
                b_rsp_valid <= 1'b0;
            end
            if (grant_a && uop_sets_flags(a_uop)) flags_out <= alu_flags;
        end
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares the single combinational `ALU` between two requesters: the execute stage (port A, architectural, owns the NZCV flags) and the load/store address unit (port B, address-only). Arbitrates one operation per cycle, registers each result in a per-port response slot with valid/ready backpressure, and holds the architectural flags register updated only by flag-setting port A operations. Sits between decode/execute and the register file / memory address path.

## Interface
- No parameters; widths fixed at 32-bit operands, 5-bit uop.
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  port A request present
- `a_ready`  out  1  port A request accepted this cycle
- `a_lhs`, `a_rhs`  in  32 each  port A operands
- `a_uop`  in  5  port A micro-op (`Utilities` encoding)
- `b_valid`, `b_ready`, `b_lhs`, `b_rhs`, `b_uop`  same as port A, for port B
- `a_rsp_valid`  out  1  port A result slot full
- `a_rsp_ready`  in  1  port A consumer takes result
- `a_rsp_data`  out  32  port A result
- `b_rsp_valid`, `b_rsp_ready`, `b_rsp_data`  same for port B
- `flags_out`  out  `Flags` (4)  architectural NZCV register

## Operation
- Port X eligible when `x_valid` and (slot X empty or `x_rsp_ready`).
- Both eligible: winner from arbitration FSM; one eligible: it wins; none: ALU driven with uop NOP, nothing captured.
- `x_ready` = grant to X (combinational from valids, rsp state, FSM state); transfer occurs on `x_valid && x_ready`.
- Granted operands/uop muxed into the one ALU instance; result captured into slot X at clock edge, `x_rsp_valid` set.
- Slot X cleared on `x_rsp_valid && x_rsp_ready` with no new grant to X; simultaneous consume and grant reloads the slot (no bubble).
- Flags: `flags_out` loads the ALU flags only on a port A grant whose uop is ADD, SUB, AND, EOR, CMP, LSL, LSR or MOV. NOP, STR, LDR and undefined uops leave it unchanged. Port B grants never touch flags.
- CMP from port A still produces a response (difference) so the execute stage retires uniformly; the consumer discards it.
- Arbitration FSM states PRIO_A, PRIO_B (reset PRIO_A). On a contested grant (both eligible), the winner's opposite becomes priority; uncontested grants leave the state unchanged.
- Arithmetic exactly per ALU: 32-bit wrap, C is bit 32 of the 33-bit result (borrow for SUB/CMP), V signed overflow.

## Timing
- Reset (async assert, sync release): `a_rsp_valid`=`b_rsp_valid`=0, `a_rsp_data`=`b_rsp_data`=0, `flags_out`=4'b0000, FSM=PRIO_A. `a_ready`/`b_ready` 0 while reset is asserted.
- Latency: accept in cycle t, `x_rsp_valid` and data in cycle t+1; flags visible in t+1.
- Throughput: one op per cycle total; one op per port per cycle while its consumer holds `x_rsp_ready`=1.
- Slot full with `x_rsp_ready`=0: `x_ready`=0, data and valid held stable; the other port proceeds.
- Request inputs must stay stable while `x_valid`=1 and `x_ready`=0.
- Reset mid-operation: in-flight and held results are dropped, flags cleared.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority, port A always wins contention; FSM removed, port B starvable.

## Structure
- `Utilities` package: existing uop constants and `Flags`; add `sched_state_t` enum (PRIO_A, PRIO_B) and a `uop_sets_flags` function.
- One sub-module: the existing `ALU`, instantiated once. Arbitration, slots and flag register live in `alu_scheduler`.

## Test plan
- Port A ADD 0x7FFFFFFF + 0x00000001 -> t+1 `a_rsp_data`=0x80000000, `flags_out` N=1 Z=0 C=0 V=1.
- Port A CMP 5,5, then port B LDR 0x1000 + 0x20 -> `b_rsp_data`=0x00001020, flags stay Z=1 C=0 N=0 V=0.
- Both valid for 4 cycles with RR_EN, consumers ready -> grants A,B,A,B. Without the macro -> A,A,A,A, `b_ready`=0.
- `a_rsp_ready`=0 with slot A full, both valid -> `a_ready`=0, B granted every cycle, `a_rsp_data` unchanged.
- SUB 3 - 5 on A with `a_rsp_ready`=1 and a back-to-back valid -> 0xFFFFFFFE, C=1, N=1, next result the following cycle, no bubble.
- `reset_n` low mid-stream with both slots full -> all outputs 0 immediately; after release the FSM is PRIO_A.
